// File: rtl/usbh_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : usbh_port_ctrl_if
// Brief  : Port-control bundle between the root-port sequencer and the UTMI
//          PHY configuration pins plus the status/interrupt logic.
// Rev    : 1.0 - initial release
// ============================================================================
interface usbh_port_ctrl_if;
    logic       port_reset_req;
    logic [1:0] utmi_linestate;
    logic       utmi_reset;
    logic [1:0] utmi_opmode;
    logic [1:0] utmi_xcvrsel;
    logic       utmi_termsel;
    logic       utmi_dppulldown;
    logic       utmi_dmpulldown;
    logic       port_connected;
    logic       port_lowspeed;
    logic       port_resetting;
    logic       port_enabled;
    logic       evt_connect;
    logic       evt_disconnect;

    modport master (
        input  port_reset_req, utmi_linestate,
        output utmi_reset, utmi_opmode, utmi_xcvrsel, utmi_termsel,
               utmi_dppulldown, utmi_dmpulldown,
               port_connected, port_lowspeed, port_resetting, port_enabled,
               evt_connect, evt_disconnect
    );

    modport slave (
        output port_reset_req, utmi_linestate,
        input  utmi_reset, utmi_opmode, utmi_xcvrsel, utmi_termsel,
               utmi_dppulldown, utmi_dmpulldown,
               port_connected, port_lowspeed, port_resetting, port_enabled,
               evt_connect, evt_disconnect
    );
endinterface
`default_nettype wire

// File: rtl/usbh_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module : usbh_port_ctrl
// Brief  : USB host root-port sequencer: PHY reset, transceiver setup,
//          connect debounce, speed latch, bus reset and disconnect detection.
// Rev    : 1.0 - initial release
// ============================================================================
module usbh_port_ctrl #(
    parameter int unsigned PHY_RST_CYCLES  = 60,
    parameter int unsigned DEBOUNCE_CYCLES = 6000000,
    parameter int unsigned BUS_RST_CYCLES  = 3000000,
    parameter int unsigned RECOVERY_CYCLES = 600000,
    parameter int unsigned DISC_CYCLES     = 150
) (
    input  logic              aclk,
    input  logic              aresetn,
    usbh_port_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_PHY_RST      = 3'd0,
        S_DISCONNECTED = 3'd1,
        S_DEBOUNCE     = 3'd2,
        S_CONNECTED    = 3'd3,
        S_BUS_RST      = 3'd4,
        S_RECOVERY     = 3'd5,
        S_ENABLED      = 3'd6
    } state_t;

    // Each timed state lasts exactly N cycles: leave when the in-state count hits N-1.
    localparam logic [31:0] c_phy_last  = 32'(PHY_RST_CYCLES - 1);
    localparam logic [31:0] c_deb_last  = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] c_bus_last  = 32'(BUS_RST_CYCLES - 1);
    localparam logic [31:0] c_rec_last  = 32'(RECOVERY_CYCLES - 1);
    localparam logic [31:0] c_disc_last = 32'(DISC_CYCLES - 1);
    localparam logic [31:0] c_cnt_max   = 32'hFFFF_FFFF;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_se0_cnt;
    logic        r_lowspeed;
    logic        r_utmi_reset;
    logic [1:0]  r_opmode;
    logic [1:0]  r_xcvrsel;
    logic        r_termsel;
    logic        r_connected;
    logic        r_resetting;
    logic        r_enabled;
    logic        r_evt_connect;
    logic        r_evt_disconnect;

    state_t      w_next_state;
    logic        w_next_lowspeed;
    logic [31:0] w_next_cnt;
    logic [31:0] w_next_se0_cnt;
    logic        w_utmi_reset;
    logic [1:0]  w_opmode;
    logic [1:0]  w_xcvrsel;
    logic        w_termsel;
    logic        w_connected;
    logic        w_resetting;
    logic        w_enabled;
    logic        w_evt_connect;
    logic        w_evt_disconnect;

    logic        w_se0;
    logic        w_live;
    logic        w_disc;

    assign w_se0  = (bus.utmi_linestate == 2'b00);
    // Disconnect detection runs across CONNECTED, RECOVERY and ENABLED; the SE0
    // run is not broken by the RECOVERY -> ENABLED hand-over.
    assign w_live = (r_state == S_CONNECTED) || (r_state == S_RECOVERY) ||
                    (r_state == S_ENABLED);
    assign w_disc = w_live && w_se0 && (r_se0_cnt >= c_disc_last);

    always_comb begin
        w_next_state    = r_state;
        w_next_lowspeed = r_lowspeed;
        case (r_state)
            S_PHY_RST: begin
                if (r_cnt >= c_phy_last) w_next_state = S_DISCONNECTED;
            end
            S_DISCONNECTED: begin
                if (!w_se0) w_next_state = S_DEBOUNCE;
            end
            S_DEBOUNCE: begin
                if (w_se0) begin
                    w_next_state = S_DISCONNECTED;
                end else if (r_cnt >= c_deb_last) begin
                    w_next_state    = S_CONNECTED;
                    w_next_lowspeed = (bus.utmi_linestate == 2'b10);
                end
            end
            S_CONNECTED, S_ENABLED: begin
                if (w_disc)                  w_next_state = S_DISCONNECTED;
                else if (bus.port_reset_req) w_next_state = S_BUS_RST;
            end
            S_BUS_RST: begin
                if (r_cnt >= c_bus_last) w_next_state = S_RECOVERY;
            end
            S_RECOVERY: begin
                if (w_disc)                   w_next_state = S_DISCONNECTED;
                else if (r_cnt >= c_rec_last) w_next_state = S_ENABLED;
            end
            default: w_next_state = S_PHY_RST;
        endcase
        if (w_next_state == S_DISCONNECTED) w_next_lowspeed = 1'b0;

        w_next_cnt     = (w_next_state != r_state) ? 32'd0 :
                         (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 32'd1;
        w_next_se0_cnt = !(w_live && w_se0) ? 32'd0 :
                         (r_se0_cnt == c_cnt_max) ? r_se0_cnt : r_se0_cnt + 32'd1;

        // Outputs are decoded from the state being entered so they can be registered.
        w_utmi_reset = 1'b0;
        w_opmode     = 2'b00;
        w_xcvrsel    = 2'b01;
        w_termsel    = 1'b1;
        w_connected  = 1'b0;
        w_resetting  = 1'b0;
        w_enabled    = 1'b0;
        case (w_next_state)
            S_PHY_RST: w_utmi_reset = 1'b1;
            S_CONNECTED: begin
                w_connected = 1'b1;
                w_xcvrsel   = w_next_lowspeed ? 2'b10 : 2'b01;
            end
            S_BUS_RST: begin
                w_opmode    = 2'b10;
                w_xcvrsel   = 2'b00;
                w_termsel   = 1'b0;
                w_connected = 1'b1;
                w_resetting = 1'b1;
            end
            S_RECOVERY: begin
                w_connected = 1'b1;
                w_resetting = 1'b1;
                w_xcvrsel   = w_next_lowspeed ? 2'b10 : 2'b01;
            end
            S_ENABLED: begin
                w_connected = 1'b1;
                w_enabled   = 1'b1;
                w_xcvrsel   = w_next_lowspeed ? 2'b10 : 2'b01;
            end
            default: w_utmi_reset = 1'b0;
        endcase

        w_evt_connect    = (r_state == S_DEBOUNCE) && (w_next_state == S_CONNECTED);
        w_evt_disconnect = w_live && (w_next_state == S_DISCONNECTED);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state          <= S_PHY_RST;
            r_cnt            <= 32'd0;
            r_se0_cnt        <= 32'd0;
            r_lowspeed       <= 1'b0;
            r_utmi_reset     <= 1'b1;
            r_opmode         <= 2'b00;
            r_xcvrsel        <= 2'b01;
            r_termsel        <= 1'b1;
            r_connected      <= 1'b0;
            r_resetting      <= 1'b0;
            r_enabled        <= 1'b0;
            r_evt_connect    <= 1'b0;
            r_evt_disconnect <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_cnt            <= w_next_cnt;
            r_se0_cnt        <= w_next_se0_cnt;
            r_lowspeed       <= w_next_lowspeed;
            r_utmi_reset     <= w_utmi_reset;
            r_opmode         <= w_opmode;
            r_xcvrsel        <= w_xcvrsel;
            r_termsel        <= w_termsel;
            r_connected      <= w_connected;
            r_resetting      <= w_resetting;
            r_enabled        <= w_enabled;
            r_evt_connect    <= w_evt_connect;
            r_evt_disconnect <= w_evt_disconnect;
        end
    end

    assign bus.utmi_reset      = r_utmi_reset;
    assign bus.utmi_opmode     = r_opmode;
    assign bus.utmi_xcvrsel    = r_xcvrsel;
    assign bus.utmi_termsel    = r_termsel;
    assign bus.utmi_dppulldown = 1'b1;
    assign bus.utmi_dmpulldown = 1'b1;
    assign bus.port_connected  = r_connected;
    assign bus.port_lowspeed   = r_lowspeed;
    assign bus.port_resetting  = r_resetting;
    assign bus.port_enabled    = r_enabled;
    assign bus.evt_connect     = r_evt_connect;
    assign bus.evt_disconnect  = r_evt_disconnect;

endmodule
`default_nettype wire

// File: tb/tb_usbh_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_usbh_port_ctrl
// Brief  : Self-checking bench for usbh_port_ctrl against a countdown model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_usbh_port_ctrl;

    localparam int PHY  = 4;
    localparam int DEB  = 20;
    localparam int BUS  = 30;
    localparam int REC  = 10;
    localparam int DISC = 5;

    localparam int P_PHY = 0, P_IDLE = 1, P_DEB = 2, P_CONN = 3, P_BUS = 4,
                   P_REC = 5, P_EN = 6;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    usbh_port_ctrl_if bus();

    usbh_port_ctrl #(
        .PHY_RST_CYCLES (PHY),
        .DEBOUNCE_CYCLES(DEB),
        .BUS_RST_CYCLES (BUS),
        .RECOVERY_CYCLES(REC),
        .DISC_CYCLES    (DISC)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus.master)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase plus cycles left in the timed phase, SE0 run length.
    int m_phase = P_PHY;
    int m_left  = PHY;
    int m_run   = 0;
    bit m_ls    = 1'b0;
    bit m_evc   = 1'b0;
    bit m_evd   = 1'b0;

    task automatic model_step(input bit rst_n, input bit req, input logic [1:0] ls);
        bit live;
        bit se0;
        if (!rst_n) begin
            m_phase = P_PHY; m_left = PHY; m_run = 0;
            m_ls = 1'b0; m_evc = 1'b0; m_evd = 1'b0;
            return;
        end
        m_evc = 1'b0;
        m_evd = 1'b0;
        se0   = (ls == 2'b00);
        live  = (m_phase == P_CONN) || (m_phase == P_REC) || (m_phase == P_EN);
        m_run = (live && se0) ? m_run + 1 : 0;
        if (live && m_run >= DISC) begin
            m_phase = P_IDLE; m_ls = 1'b0; m_evd = 1'b1;
        end else begin
            case (m_phase)
                P_PHY: begin
                    m_left--;
                    if (m_left == 0) m_phase = P_IDLE;
                end
                P_IDLE: if (!se0) begin m_phase = P_DEB; m_left = DEB; end
                P_DEB: begin
                    if (se0) m_phase = P_IDLE;
                    else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = P_CONN; m_ls = (ls == 2'b10); m_evc = 1'b1;
                        end
                    end
                end
                P_CONN, P_EN: if (req) begin m_phase = P_BUS; m_left = BUS; end
                P_BUS: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_REC; m_left = REC; end
                end
                P_REC: begin
                    m_left--;
                    if (m_left == 0) m_phase = P_EN;
                end
                default: m_phase = P_PHY;
            endcase
        end
    endtask

    function automatic logic [13:0] exp_vec();
        bit att;
        logic [1:0] xc;
        att = (m_phase == P_CONN) || (m_phase == P_BUS) || (m_phase == P_REC) || (m_phase == P_EN);
        xc  = (m_phase == P_BUS) ? 2'b00 : (att && m_ls) ? 2'b10 : 2'b01;
        return {m_phase == P_PHY, (m_phase == P_BUS) ? 2'b10 : 2'b00, xc,
                m_phase != P_BUS, 1'b1, 1'b1, att, m_ls,
                (m_phase == P_BUS) || (m_phase == P_REC), m_phase == P_EN, m_evc, m_evd};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {bus.utmi_reset, bus.utmi_opmode, bus.utmi_xcvrsel, bus.utmi_termsel,
                bus.utmi_dppulldown, bus.utmi_dmpulldown, bus.port_connected,
                bus.port_lowspeed, bus.port_resetting, bus.port_enabled,
                bus.evt_connect, bus.evt_disconnect};
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit rst_n, input bit req, input logic [1:0] ls);
        aresetn            = rst_n;
        bus.port_reset_req = req;
        bus.utmi_linestate = ls;
        @(posedge aclk);
        model_step(rst_n, req, ls);
        @(negedge aclk);
    endtask

    task automatic drive(input int n, input bit req, input logic [1:0] ls);
        for (int i = 0; i < n; i++) cycle(1'b1, req, ls);
    endtask

    task automatic test_reset();
        int rcnt;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 2'b00);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL reset_hold cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        rcnt = int'(bus.utmi_reset);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 2'b00);
            rcnt += int'(bus.utmi_reset);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL phy_release cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (rcnt !== PHY) begin
            n_bad++; $display("FAIL phy_reset_len: got %0d want %0d", rcnt, PHY);
        end
    endtask

    task automatic test_connect_fs();
        int at = 0, pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            cycle(1'b1, 1'b0, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL connect_fs cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            if (bus.evt_connect === 1'b1) begin pulses++; if (at == 0) at = i; end
        end
        n_cmp++;
        if (at !== DEB + 1 || pulses !== 1) begin
            n_bad++; $display("FAIL connect_fs_timing: got at=%0d pulses=%0d want at=%0d pulses=1", at, pulses, DEB + 1);
        end
        n_cmp++;
        if (bus.port_connected !== 1'b1 || bus.port_lowspeed !== 1'b0 || bus.utmi_xcvrsel !== 2'b01) begin
            n_bad++; $display("FAIL connect_fs_status: got conn=%b ls=%b xc=%b want 1 0 01",
                              bus.port_connected, bus.port_lowspeed, bus.utmi_xcvrsel);
        end
    endtask

    task automatic test_disc_connected();
        int at = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, 2'b00);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL disc_conn cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            if (bus.evt_disconnect === 1'b1 && at == 0) at = i;
        end
        n_cmp++;
        if (at !== DISC) begin
            n_bad++; $display("FAIL disc_conn_timing: got %0d want %0d", at, DISC);
        end
    endtask

    task automatic test_connect_ls_glitch();
        int at = 0, pulses = 0;
        for (int i = 1; i <= 42; i++) begin
            cycle(1'b1, 1'b0, (i == 12) ? 2'b00 : 2'b10);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL connect_ls cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            if (bus.evt_connect === 1'b1) begin pulses++; if (at == 0) at = i - 12; end
        end
        n_cmp++;
        if (at !== DEB + 1 || pulses !== 1) begin
            n_bad++; $display("FAIL connect_ls_timing: got at=%0d pulses=%0d want at=%0d pulses=1", at, pulses, DEB + 1);
        end
        n_cmp++;
        if (bus.port_lowspeed !== 1'b1 || bus.utmi_xcvrsel !== 2'b10) begin
            n_bad++; $display("FAIL connect_ls_status: got ls=%b xc=%b want 1 10", bus.port_lowspeed, bus.utmi_xcvrsel);
        end
    endtask

    task automatic test_bus_reset();
        int bus_cnt = 0, rec_cnt = 0, dcnt = 0;
        cycle(1'b1, 1'b1, 2'b10);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL bus_rst_start: got %b want %b", dut_vec(), exp_vec());
        end
        if (bus.utmi_opmode === 2'b10) bus_cnt++;
        for (int i = 1; i <= 50; i++) begin
            cycle(1'b1, (i <= 40) && ($urandom_range(0, 5) == 0),
                  (i <= 30) ? 2'($urandom_range(0, 3)) : 2'b10);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL bus_rst cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            if (bus.utmi_opmode === 2'b10 && bus.utmi_xcvrsel === 2'b00 && bus.utmi_termsel === 1'b0) bus_cnt++;
            if (bus.port_resetting === 1'b1 && bus.utmi_opmode === 2'b00 && bus.utmi_termsel === 1'b1) rec_cnt++;
            if (bus.evt_disconnect === 1'b1) dcnt++;
        end
        n_cmp++;
        if (bus_cnt !== BUS || rec_cnt !== REC || dcnt !== 0) begin
            n_bad++; $display("FAIL bus_rst_seq: got bus=%0d rec=%0d disc=%0d want %0d %0d 0",
                              bus_cnt, rec_cnt, dcnt, BUS, REC);
        end
        n_cmp++;
        if (bus.port_enabled !== 1'b1 || bus.port_resetting !== 1'b0) begin
            n_bad++; $display("FAIL bus_rst_end: got en=%b rst=%b want 1 0", bus.port_enabled, bus.port_resetting);
        end
    endtask

    task automatic test_glitch_enabled();
        int dcnt = 0;
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 1'b0, (i == 5) ? 2'b01 : 2'b00);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL en_glitch cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (bus.port_enabled !== 1'b1) begin
            n_bad++; $display("FAIL en_glitch_hold: got en=%b want 1", bus.port_enabled);
        end
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, 1'b0, 2'b00);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL en_disc cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            if (bus.evt_disconnect === 1'b1) dcnt++;
        end
        n_cmp++;
        if (dcnt !== 1 || bus.port_connected !== 1'b0 || bus.port_enabled !== 1'b0 ||
            bus.port_lowspeed !== 1'b0 || bus.port_resetting !== 1'b0) begin
            n_bad++; $display("FAIL en_disc_status: got pulses=%0d conn=%b en=%b ls=%b rst=%b want 1 0 0 0 0",
                              dcnt, bus.port_connected, bus.port_enabled, bus.port_lowspeed, bus.port_resetting);
        end
    endtask

    task automatic test_priority();
        drive(DEB + 2, 1'b0, 2'b01);
        drive(DISC - 1, 1'b0, 2'b00);
        cycle(1'b1, 1'b1, 2'b00);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL req_vs_disc: got %b want %b", dut_vec(), exp_vec());
        end
        n_cmp++;
        if (bus.evt_disconnect !== 1'b1 || bus.port_resetting !== 1'b0 || bus.utmi_opmode !== 2'b00) begin
            n_bad++; $display("FAIL req_vs_disc_win: got evd=%b rst=%b op=%b want 1 0 00",
                              bus.evt_disconnect, bus.port_resetting, bus.utmi_opmode);
        end
    endtask

    task automatic test_mid_reset();
        logic [13:0] want;
        want = 14'b1_00_01_1_1_1_0_0_0_0_0_0;
        drive(DEB + 2, 1'b0, 2'b01);
        cycle(1'b1, 1'b1, 2'b01);
        drive(10, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 2'b01);
        n_cmp++;
        if (dut_vec() !== want) begin
            n_bad++; $display("FAIL mid_bus_rst_reset: got %b want %b", dut_vec(), want);
        end
    endtask

    task automatic test_random();
        logic [1:0] ls;
        int len;
        for (int s = 0; s < 70; s++) begin
            ls  = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) begin
                cycle($urandom_range(0, 299) != 0, $urandom_range(0, 15) == 0, ls);
                n_cmp++;
                if (dut_vec() !== exp_vec()) begin
                    n_bad++; $display("FAIL random seg %0d cyc %0d: got %b want %b", s, i, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        bus.port_reset_req = 1'b0;
        bus.utmi_linestate = 2'b00;
        @(negedge aclk);
        test_reset();
        test_connect_fs();
        test_disc_connected();
        test_connect_ls_glitch();
        test_bus_reset();
        test_glitch_enabled();
        test_priority();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usbh_port_ctrl.md
Name: usbh_port_ctrl

Overview:
- Root-port sequencer for the USB host's single UTMI PHY: owns PHY reset, transceiver configuration (opmode/xcvrsel/termsel/pulldowns), connect debounce, speed detection, host bus-reset timing and disconnect detection.
- Sits beside the USB host core. The host core keeps the UTMI data/tx/rx path; this block drives the UTMI configuration pins and reports port status to the register/interrupt logic.
- Clocked by the 60 MHz UTMI clock, which is also the AXI clock.

Parameters:
- PHY_RST_CYCLES, 60: cycles utmi_reset is held after reset release.
- DEBOUNCE_CYCLES, 6000000: cycles of continuous non-SE0 required to declare a connect (100 ms).
- BUS_RST_CYCLES, 3000000: duration of the host-driven bus reset (50 ms).
- RECOVERY_CYCLES, 600000: reset-recovery wait before the port is enabled (10 ms).
- DISC_CYCLES, 150: cycles of continuous SE0 while enabled or connected that declare a disconnect.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- port_reset_req  in  1  single-cycle request to start a bus reset
- utmi_linestate  in  2  PHY line state {D-,D+}: 00 SE0, 01 J(FS), 10 K/J(LS), 11 SE1
- utmi_reset  out  1  PHY reset
- utmi_opmode  out  2  PHY operating mode
- utmi_xcvrsel  out  2  transceiver select
- utmi_termsel  out  1  termination select
- utmi_dppulldown  out  1  D+ pulldown enable
- utmi_dmpulldown  out  1  D- pulldown enable
- port_connected  out  1  device present (debounced)
- port_lowspeed  out  1  latched speed; valid while port_connected
- port_resetting  out  1  bus reset or recovery in progress
- port_enabled  out  1  port usable for traffic
- evt_connect  out  1  one-cycle pulse on connect
- evt_disconnect  out  1  one-cycle pulse on disconnect

Behaviour:
- Reset (aresetn=0 sampled at a rising edge):
  - state = PHY_RST, counter = 0.
  - utmi_reset=1, opmode=00, xcvrsel=01, termsel=1, pulldowns=1/1.
  - All status outputs and events = 0.
- Reset has the same effect when asserted mid-operation, from any state.
- All outputs are registered. Counter is 32-bit, cleared on every state change, saturating.
- The pulldowns are 1 in every state (host mode).
- PHY_RST:
  - utmi_reset=1 for exactly PHY_RST_CYCLES cycles, then 0.
  - Then -> DISCONNECTED.
- DISCONNECTED:
  - linestate != 00 -> DEBOUNCE.
- DEBOUNCE:
  - Any linestate==00 -> DISCONNECTED, with counter cleared.
  - When the counter reaches DEBOUNCE_CYCLES -> CONNECTED. On that transition:
    - port_lowspeed = (linestate==10);
    - evt_connect pulses;
    - port_connected = 1.
  - linestate 11 counts as non-SE0.
- CONNECTED:
  - port_reset_req -> BUS_RST.
  - DISC_CYCLES of consecutive SE0 -> DISCONNECTED.
  - xcvrsel = 10 if lowspeed, else 01.
- BUS_RST:
  - opmode=10, xcvrsel=00, termsel=0 (drives SE0 while the host core holds txvalid low).
  - port_resetting=1, port_enabled=0.
  - Disconnect detection is suppressed.
  - After BUS_RST_CYCLES -> RECOVERY.
- RECOVERY:
  - opmode=00, xcvrsel=10 (LS) or 01 (FS), termsel=1.
  - port_resetting stays 1.
  - After RECOVERY_CYCLES -> ENABLED.
- ENABLED:
  - port_enabled=1.
  - port_reset_req -> BUS_RST (re-reset is allowed).
  - DISC_CYCLES of consecutive SE0 -> DISCONNECTED.
- Any transition to DISCONNECTED from CONNECTED, RECOVERY or ENABLED:
  - evt_disconnect pulses;
  - port_connected=0, port_enabled=0, port_resetting=0, port_lowspeed=0.
  - The SE0 run counter restarts on every non-SE0 sample.
- RECOVERY runs disconnect detection exactly as ENABLED does.
- port_reset_req is ignored in PHY_RST, DISCONNECTED, DEBOUNCE, BUS_RST and RECOVERY; it is not queued.
- If port_reset_req and the disconnect threshold occur in the same cycle, disconnect wins.
- evt_connect and evt_disconnect are never asserted together. Each pulse is high for exactly one cycle.

Test Plan:
- Parameters for all scenarios: PHY_RST_CYCLES=4, DEBOUNCE_CYCLES=20, BUS_RST_CYCLES=30, RECOVERY_CYCLES=10, DISC_CYCLES=5.
- Reset release, then hold linestate=00 -> utmi_reset=1 for exactly 4 cycles then 0; all status outputs stay 0; pulldowns=1.
- linestate=01 for 20 cycles -> evt_connect pulses once; port_connected=1, port_lowspeed=0, xcvrsel=01.
- linestate=10 with one 00 glitch at cycle 12, then steady 10 -> no connect until 20 cycles after the glitch; then port_lowspeed=1, xcvrsel=10.
- port_reset_req in CONNECTED -> exact sequence:
  - opmode=10, xcvrsel=00, termsel=0 for 30 cycles;
  - then opmode=00, termsel=1, port_resetting=1 for 10 cycles;
  - then port_enabled=1, port_resetting=0.
  - 00 on linestate during BUS_RST causes no disconnect.
- ENABLED with linestate=00 for 4 cycles, then 01 -> stays enabled. Then 00 for 5 cycles -> evt_disconnect pulses and all status outputs go 0.
- aresetn=0 mid-BUS_RST -> next cycle opmode=00, xcvrsel=01, termsel=1, utmi_reset=1, status outputs 0.
